// File: rtl/md_unit_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit.
//   md_op_e    : encoding of the md_op operation field
//   md_state_e : sequencer state codes
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_unit_calc.sv
// Combinational arithmetic core of the multiply/divide unit.
//   op       : md_op of the instruction in E (only 1..4 produce a result)
//   rs_data  : first operand (multiplicand / dividend)
//   rt_data  : second operand (multiplier / divisor)
//   hi, lo   : 64-bit result split as {hi, lo}; for divides hi=remainder, lo=quotient
//   div_zero : a divide whose divisor is zero (result must not be written back)
module md_calc
  import md_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  // Signed divide with the one overflowing case pinned: -2^31 / -1 has no
  // representable quotient, so it yields quotient -2^31 and remainder 0.
  // Returns {remainder, quotient}.
  function automatic logic [63:0] sdiv_sat(input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'sd0) begin
      q = 32'sd0;
      r = 32'sd0;
    end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
      q = 32'sh8000_0000;
      r = 32'sd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] udiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic signed [31:0] rs_s;
  logic signed [31:0] rt_s;
  logic signed [63:0] rs_x;
  logic signed [63:0] rt_x;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] res;

  always_comb begin
    rs_s   = rs_data;
    rt_s   = rt_data;
    rs_x   = {{32{rs_data[31]}}, rs_data};
    rt_x   = {{32{rt_data[31]}}, rt_data};
    prod_s = rs_x * rt_x;
    prod_u = {32'd0, rs_data} * {32'd0, rt_data};
    res    = 64'd0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   res = sdiv_sat(rs_s, rt_s);
      MD_DIVU:  res = udiv(rs_data, rt_data);
      default:  res = 64'd0;
    endcase
    hi       = res[63:32];
    lo       = res[31:0];
    div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (rt_data == 32'd0);
  end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
//   clk, reset : clock and synchronous active-high reset
//   md_op      : operation of the E-stage instruction (md_op_e encoding)
//   rs_data    : forwarded rs operand
//   rt_data    : forwarded rt operand
//   Req        : CP0 exception/interrupt request; flushes the E instruction
//   start      : an md op 1..4 is being issued this cycle
//   busy       : an operation is in flight
//   HI_LO      : HI for mfhi, LO for mflo, else 0
//   HI, LO     : architectural registers
// The result is computed when the op is accepted and parked in p_hi/p_lo;
// the busy countdown only models latency before it is committed.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        Req,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI_LO,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e   state;
  md_state_e   state_nxt;
  logic [3:0]  cnt;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        p_wr;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_dz;
  logic        is_div;
  logic        accept;
  logic        done;
  logic        mthi_wr;
  logic        mtlo_wr;

  md_calc u_calc (
    .op       (md_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .hi       (calc_hi),
    .lo       (calc_lo),
    .div_zero (calc_dz)
  );

  always_comb begin
    start   = ((md_op == MD_MULT) || (md_op == MD_MULTU) ||
               (md_op == MD_DIV)  || (md_op == MD_DIVU)) && !Req;
    is_div  = (md_op == MD_DIV) || (md_op == MD_DIVU);
    // An md op arriving while busy is illegal and simply ignored.
    accept  = start && (state == MD_IDLE);
    done    = (state == MD_BUSY) && (cnt == 4'd1);
    mthi_wr = (md_op == MD_MTHI) && !Req;
    mtlo_wr = (md_op == MD_MTLO) && !Req;
    busy    = (state == MD_BUSY);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept) state_nxt = MD_BUSY;
      MD_BUSY: if (done)   state_nxt = MD_IDLE;
      default:             state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    case (md_op)
      MD_MFHI: HI_LO = HI;
      MD_MFLO: HI_LO = LO;
      default: HI_LO = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 4'd0;
      p_wr <= 1'b0;
    end else if (accept) begin
      cnt  <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      p_wr <= !calc_dz;
    end else if (state == MD_BUSY) begin
      cnt  <= cnt - 4'd1;
    end
  end

  // Pending result is pure data; p_wr gates whether it is ever committed.
  always_ff @(posedge clk) begin
    if (accept) begin
      p_hi <= calc_hi;
      p_lo <= calc_lo;
    end
  end

  // Completion takes priority over a (hazard-violating) concurrent mthi/mtlo.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else begin
      if (done && p_wr)  HI <= p_hi;
      else if (mthi_wr)  HI <= rs_data;
      if (done && p_wr)  LO <= p_lo;
      else if (mtlo_wr)  LO <= rs_data;
    end
  end

endmodule
